// File: rtl/riscv_pipe_core.sv
// Five-stage RV32I-subset pipeline (ADD/SUB/AND/OR/SLT/ADDI/LW/SW/BEQ) with local IMEM/DMEM.
// Define RISCV_FORWARDING_EN for EX bypassing plus load-use stall; otherwise ID interlocks on EX/MEM producers.
module riscv_pipe_core #(
   parameter int XLEN       = 32,
   parameter int IMEM_DEPTH = 1024,
   parameter int DMEM_DEPTH = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          imem_we,
   input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
   input  logic [31:0]                   imem_wdata,
   input  logic [4:0]                    dbg_raddr,
   output logic [XLEN-1:0]               dbg_rdata,
   output logic [XLEN-1:0]               pc,
   output logic                          retire_valid,
   output logic [4:0]                    retire_rd,
   output logic [XLEN-1:0]               retire_data
);
   localparam int IA = $clog2(IMEM_DEPTH);
   localparam int DA = $clog2(DMEM_DEPTH);
   localparam int SH = $clog2(XLEN / 8);
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [6:0]  OP_R    = 7'b0110011;
   localparam logic [6:0]  OP_ADDI = 7'b0010011;
   localparam logic [6:0]  OP_LW   = 7'b0000011;
   localparam logic [6:0]  OP_SW   = 7'b0100011;
   localparam logic [6:0]  OP_BEQ  = 7'b1100011;

   function automatic logic is_legal(input logic [31:0] ir);
      logic [2:0] f3;
      f3 = ir[14:12];
      case (ir[6:0])
         OP_R:    is_legal = (ir[31:25] == 7'h00 && (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7))
                             || (ir[31:25] == 7'h20 && f3 == 3'd0);
         OP_ADDI: is_legal = (f3 == 3'd0);
         OP_LW:   is_legal = (f3 == 3'd2);
         OP_SW:   is_legal = (f3 == 3'd2);
         OP_BEQ:  is_legal = (f3 == 3'd0);
         default: is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic writes_rd(input logic [31:0] ir);
      writes_rd = (ir[6:0] == OP_R || ir[6:0] == OP_ADDI || ir[6:0] == OP_LW) && (ir[11:7] != 5'd0);
   endfunction

   function automatic logic reads_rs1(input logic [31:0] ir);
      reads_rs1 = (ir[6:0] == OP_R || ir[6:0] == OP_ADDI || ir[6:0] == OP_LW
                   || ir[6:0] == OP_SW || ir[6:0] == OP_BEQ);
   endfunction

   function automatic logic reads_rs2(input logic [31:0] ir);
      reads_rs2 = (ir[6:0] == OP_R || ir[6:0] == OP_SW || ir[6:0] == OP_BEQ);
   endfunction

   // True when cons reads a register that prod is going to write.
   function automatic logic hazard(input logic [31:0] prod, input logic [31:0] cons);
      hazard = writes_rd(prod) && ((reads_rs1(cons) && prod[11:7] == cons[19:15])
                                || (reads_rs2(cons) && prod[11:7] == cons[24:20]));
   endfunction

   logic [31:0]     imem [IMEM_DEPTH];
   logic [XLEN-1:0] dmem [DMEM_DEPTH];
   logic [XLEN-1:0] regs_q [32];

   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     ifid_ir_q, ifid_ir_d, idex_ir_q, idex_ir_d;
   logic [31:0]     exmem_ir_q, exmem_ir_d, memwb_ir_q, memwb_ir_d;
   logic            ifid_v_q, ifid_v_d, idex_v_q, idex_v_d;
   logic            exmem_v_q, exmem_v_d, memwb_v_q, memwb_v_d;
   logic [XLEN-1:0] ifid_pc_q, ifid_pc_d, idex_pc_q, idex_pc_d;
   logic [XLEN-1:0] idex_a_q, idex_a_d, idex_b_q, idex_b_d;
   logic [XLEN-1:0] exmem_alu_q, exmem_alu_d, exmem_sd_q, exmem_sd_d;
   logic [XLEN-1:0] memwb_res_q, memwb_res_d;

   logic [31:0]     fetch_ir, id_ir;
   logic            wb_we, stall, ex_taken;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] ex_a, ex_b, ex_alu, ex_target;
   logic [XLEN-1:0] imm_i, imm_s, imm_b;
   logic [XLEN-1:0] mem_ld;

   always_ff @(posedge clk) begin
      if (imem_we) imem[imem_waddr] <= imem_wdata;
   end

   // ---- IF / ID
   assign fetch_ir = imem[pc_q[IA+1:2]];
   assign id_ir    = is_legal(ifid_ir_q) ? ifid_ir_q : NOP;
   assign wb_we    = memwb_v_q && writes_rd(memwb_ir_q);
   assign wb_rd    = memwb_ir_q[11:7];

   // Register reads see a same-cycle WB write (write-through).
   always_comb begin
      idex_a_d = '0;
      idex_b_d = '0;
      if (id_ir[19:15] != 5'd0)
         idex_a_d = (wb_we && wb_rd == id_ir[19:15]) ? memwb_res_q : regs_q[id_ir[19:15]];
      if (id_ir[24:20] != 5'd0)
         idex_b_d = (wb_we && wb_rd == id_ir[24:20]) ? memwb_res_q : regs_q[id_ir[24:20]];
   end

`ifdef RISCV_FORWARDING_EN
   assign stall = (idex_ir_q[6:0] == OP_LW) && hazard(idex_ir_q, id_ir);
`else
   assign stall = hazard(idex_ir_q, id_ir) || hazard(exmem_ir_q, id_ir);
`endif

   // ---- EX
   assign imm_i = {{(XLEN-12){idex_ir_q[31]}}, idex_ir_q[31:20]};
   assign imm_s = {{(XLEN-12){idex_ir_q[31]}}, idex_ir_q[31:25], idex_ir_q[11:7]};
   assign imm_b = {{(XLEN-12){idex_ir_q[31]}}, idex_ir_q[7], idex_ir_q[30:25], idex_ir_q[11:8], 1'b0};

   always_comb begin
      ex_a = idex_a_q;
      ex_b = idex_b_q;
`ifdef RISCV_FORWARDING_EN
      if (writes_rd(exmem_ir_q) && exmem_ir_q[6:0] != OP_LW && exmem_ir_q[11:7] == idex_ir_q[19:15])
         ex_a = exmem_alu_q;
      else if (wb_we && wb_rd == idex_ir_q[19:15])
         ex_a = memwb_res_q;
      if (writes_rd(exmem_ir_q) && exmem_ir_q[6:0] != OP_LW && exmem_ir_q[11:7] == idex_ir_q[24:20])
         ex_b = exmem_alu_q;
      else if (wb_we && wb_rd == idex_ir_q[24:20])
         ex_b = memwb_res_q;
`endif
   end

   always_comb begin
      ex_alu = '0;
      case (idex_ir_q[6:0])
         OP_R: begin
            case (idex_ir_q[14:12])
               3'd0:    ex_alu = idex_ir_q[30] ? ex_a - ex_b : ex_a + ex_b;
               3'd2:    ex_alu = {{(XLEN-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
               3'd6:    ex_alu = ex_a | ex_b;
               3'd7:    ex_alu = ex_a & ex_b;
               default: ex_alu = '0;
            endcase
         end
         OP_ADDI, OP_LW: ex_alu = ex_a + imm_i;
         OP_SW:          ex_alu = ex_a + imm_s;
         default:        ex_alu = '0;
      endcase
   end

   assign ex_taken  = idex_v_q && (idex_ir_q[6:0] == OP_BEQ) && (ex_a == ex_b);
   assign ex_target = idex_pc_q + imm_b;

   // ---- MEM
   assign mem_ld = dmem[exmem_alu_q[DA+SH-1:SH]];

   always_ff @(posedge clk) begin
      if (exmem_v_q && exmem_ir_q[6:0] == OP_SW) dmem[exmem_alu_q[DA+SH-1:SH]] <= exmem_sd_q;
   end

   // A taken branch overrides a simultaneous stall.
   always_comb begin
      pc_d       = pc_q + XLEN'(4);
      ifid_ir_d  = fetch_ir;
      ifid_pc_d  = pc_q;
      ifid_v_d   = 1'b1;
      idex_ir_d  = id_ir;
      idex_pc_d  = ifid_pc_q;
      idex_v_d   = ifid_v_q;
      if (ex_taken) begin
         pc_d      = ex_target;
         ifid_ir_d = NOP;
         ifid_v_d  = 1'b0;
         idex_ir_d = NOP;
         idex_v_d  = 1'b0;
      end else if (stall) begin
         pc_d      = pc_q;
         ifid_ir_d = ifid_ir_q;
         ifid_pc_d = ifid_pc_q;
         ifid_v_d  = ifid_v_q;
         idex_ir_d = NOP;
         idex_v_d  = 1'b0;
      end
      exmem_ir_d  = idex_ir_q;
      exmem_v_d   = idex_v_q;
      exmem_alu_d = ex_alu;
      exmem_sd_d  = ex_b;
      memwb_ir_d  = exmem_ir_q;
      memwb_v_d   = exmem_v_q;
      memwb_res_d = (exmem_ir_q[6:0] == OP_LW) ? mem_ld : exmem_alu_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= '0;
         ifid_ir_q  <= NOP;
         idex_ir_q  <= NOP;
         exmem_ir_q <= NOP;
         memwb_ir_q <= NOP;
         ifid_v_q   <= 1'b0;
         idex_v_q   <= 1'b0;
         exmem_v_q  <= 1'b0;
         memwb_v_q  <= 1'b0;
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else begin
         pc_q       <= pc_d;
         ifid_ir_q  <= ifid_ir_d;
         idex_ir_q  <= idex_ir_d;
         exmem_ir_q <= exmem_ir_d;
         memwb_ir_q <= memwb_ir_d;
         ifid_v_q   <= ifid_v_d;
         idex_v_q   <= idex_v_d;
         exmem_v_q  <= exmem_v_d;
         memwb_v_q  <= memwb_v_d;
         if (wb_we) regs_q[wb_rd] <= memwb_res_q;
      end
   end

   always_ff @(posedge clk) begin
      ifid_pc_q   <= ifid_pc_d;
      idex_pc_q   <= idex_pc_d;
      idex_a_q    <= idex_a_d;
      idex_b_q    <= idex_b_d;
      exmem_alu_q <= exmem_alu_d;
      exmem_sd_q  <= exmem_sd_d;
      memwb_res_q <= memwb_res_d;
   end

   // ---- WB
   assign pc           = pc_q;
   assign retire_valid = memwb_v_q;
   assign retire_rd    = wb_we ? wb_rd : 5'd0;
   assign retire_data  = wb_we ? memwb_res_q : '0;
   assign dbg_rdata    = (dbg_raddr == 5'd0) ? '0 : regs_q[dbg_raddr];

endmodule

// File: doc/riscv_pipe_core.md
RISCV_PIPE_CORE -- requirements
Module: riscv_pipe_core

Interface
REQ-001 Parameter XLEN, default 32: datapath and register width; legal values 32 or 64.
REQ-002 Parameter IMEM_DEPTH, default 1024: instruction memory depth in 32-bit words; power of 2.
REQ-003 Parameter DMEM_DEPTH, default 1024: data memory depth in XLEN words; power of 2.
REQ-004 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port imem_we, input, 1: instruction-memory write strobe (program load).
REQ-007 Port imem_waddr, input, log2(IMEM_DEPTH): instruction word address.
REQ-008 Port imem_wdata, input, 32: instruction word.
REQ-009 Port dbg_raddr, input, 5: register-file debug read index.
REQ-010 Port dbg_rdata, output, XLEN: combinational Regs[dbg_raddr]; x0 reads 0.
REQ-011 Port pc, output, XLEN: current fetch PC.
REQ-012 Port retire_valid, output, 1: one-cycle pulse per instruction leaving WB (NOP bubbles excluded).
REQ-013 Port retire_rd, output, 5: rd of the retiring instruction; 0 for SW/BEQ.
REQ-014 Port retire_data, output, XLEN: value written to rd; 0 when nothing is written.

Function
REQ-015 5-stage pipeline IF/ID/EX/MEM/WB; one instruction per cycle absent hazards.
REQ-016 Supported ops: ADD, SUB, AND, OR, SLT (R-type 0110011); ADDI (0010011); LW (0000011); SW (0100011); BEQ (1100011). All other encodings execute as NOP (ADDI x0,x0,0 = 0x00000013), with retire_valid still pulsed.
REQ-017 Immediates: I, S and B formats, sign-extended to XLEN; BEQ offset is imm<<1 relative to the BEQ's own PC.
REQ-018 Arithmetic wraps modulo 2^XLEN; SLT is a signed compare producing 0 or 1.
REQ-019 Memory addressing: IMEM index = pc[log2(IMEM_DEPTH)+1:2]; DMEM index = addr >> log2(XLEN/8), truncated (wrap-around, no fault).
REQ-020 Register file: x0 hard-wired to 0; a WB write in cycle N is visible to the ID read in the same cycle N (write-through).
REQ-021 Forwarding into EX operands, priority EX/MEM (ALU result) over MEM/WB (ALU result or load data) over register file; never forward from rd=0.
REQ-022 Load-use hazard: a LW in EX whose rd≠0 matches the rs1/rs2 used by the instruction in ID → hold PC and IF/ID, inject a bubble into ID/EX; exactly 1 stall cycle.
REQ-023 Only the sources an opcode actually reads count as hazards: ADDI and LW read rs1; R-type, SW and BEQ read rs1 and rs2.
REQ-024 BEQ is resolved in EX using forwarded operands. If taken: pc ← target, IF/ID and ID/EX ← NOP, 2-cycle penalty. If not taken: no penalty.
REQ-025 A taken branch and a stall in the same cycle: the branch wins, the stall is discarded and the flush proceeds.
REQ-026 SW writes DMEM in MEM; LW reads DMEM in MEM (synchronous write, combinational read); SW followed by LW to the same address returns the stored data.
REQ-027 An imem_we write is visible to a fetch of that address on the following cycle; writes are allowed in and out of reset.
REQ-028 PC increments by 4 per unstalled cycle and wraps modulo 2^XLEN.

Reset
REQ-029 rst_n low asynchronously sets: pc=0; all four pipeline IRs = NOP; Regs x1..x31 = 0; retire_valid=0, retire_rd=0, retire_data=0.
REQ-030 Reset asserted mid-operation discards all in-flight instructions; DMEM and IMEM contents are preserved.
REQ-031 The first fetch from address 0 occurs on the first rising clk after rst_n deasserts.

Configuration
REQ-032 Macro RISCV_FORWARDING_EN. When defined, REQ-021 and REQ-022 apply.
REQ-033 When RISCV_FORWARDING_EN is undefined, there are no bypass paths: ID stalls while any instruction in EX or MEM has rd≠0 equal to a source read per REQ-023. The results are architecturally identical; only cycle counts differ.

Verification
REQ-034 Scenario: ADDI x1,x0,5; ADD x2,x1,x1; ADD x3,x2,x1 → x3=15; 3 retirements in 3 consecutive cycles with forwarding enabled.
REQ-035 Scenario: SW x1 (=7),0(x0); LW x4,0(x0); ADD x5,x4,x4 → x5=14; exactly 1 bubble (retire_valid low once) between LW and ADD.
REQ-036 Scenario: BEQ x0,x0,+8 followed by ADDI x6,x0,1 → x6 remains 0; the target instruction retires with 2 idle retire cycles after the BEQ.
REQ-037 Scenario: BEQ x1,x2 not taken (x1=1, x2=2) → the fall-through instruction retires in the next cycle.
REQ-038 Scenario: ADDI x0,x0,9; ADD x7,x0,x0 → x7=0; dbg_raddr=0 reads 0.
REQ-039 Scenario: rst_n pulsed low mid-program → pc=0 and retire_valid=0 immediately; after release the program re-executes with identical results; both macro settings give identical final register state.
